piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per CLK on a single-bit serial line with framing flags.
- It is the transmit end for our serial-in shift-register chains and for the matching deserializer.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 4, data word width in bits; legal range 1 to 64.
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- I  input  WIDTH  parallel word to transmit.
- I_valid  input  1  upstream word valid.
- I_ready  output  1  block can accept a word this cycle.
- O  output  1  serial data bit.
- O_valid  output  1  O carries a frame bit this cycle.
- O_last  output  1  O is the final bit of the current frame.

Behaviour:
- Reset: on ASYNCRESETN low, immediately and without waiting for a clock edge:
  - shift register = 0, bit counter = 0, state = IDLE;
  - O = 0, O_valid = 0, O_last = 0;
  - I_ready is forced to 0 while reset is held.
- Reset may arrive mid-frame. The partial frame is discarded and is not resumed.
- States: IDLE and SHIFT.
- IDLE:
  - I_ready = 1, O_valid = 0, O = 0.
  - On an edge where I_valid and I_ready are both high: load I into the shift register, set counter = FRAME_LEN-1, go to SHIFT.
- SHIFT:
  - O_valid = 1.
  - O = shift-register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1), driven combinationally from the register with no extra pipeline stage.
  - O_last = 1 when counter == 0.
  - Each edge: shift toward the output end, zero-fill, decrement counter.
- Frame end (counter == 0):
  - I_ready = 1 in this cycle.
  - If I_valid is high, the new word loads at this edge, the state stays SHIFT and the next frame's first bit appears on the next cycle with no gap.
  - Otherwise the state returns to IDLE.
- I_ready = 0 during every other SHIFT cycle. I_valid asserted then is not accepted.
- Upstream must hold I and I_valid stable until the handshake completes.
- Latency: first bit of a word is on O the cycle after the accepting edge.
- FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Counter width = clog2(FRAME_LEN+1).
- Boundary, WIDTH=1: every frame is a single cycle with O_last=1. Continuous I_valid yields O_valid held high with I_ready high every cycle.
- Boundary, I_valid deasserting after a handshake: has no effect on the frame in flight.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, computed and registered at load) is sent as one extra bit after the data.
  - O_last marks the parity bit, not the last data bit.
  - FRAME_LEN = WIDTH+1.
- Undefined:
  - No parity logic or parity register exists.
  - FRAME_LEN = WIDTH and O_last marks the last data bit.
- Port list is identical in both builds.

Decomposition:
- Shared package serializer_pkg, holding:
  - the state enum (IDLE, SHIFT);
  - a clog2-based counter-width function;
  - the LSB_FIRST encoding constants.
- The matching deserializer reuses this package.
- One natural sub-module: piso_shift_reg.
  - Inputs: load, shift, data.
  - Behaviour: parameterised direction, outputs the output-end bit.
  - Ownership: the top-level piso_serializer keeps the FSM, counter, handshake and parity.

Test Plan:
- Reset, WIDTH=4: pull ASYNCRESETN low on the 2nd bit of a frame -> O_valid=0, O=0, O_last=0 and I_ready=0 with no clock edge; after release, I_ready=1 and the next word transmits in full.
- Single word, WIDTH=4, LSB_FIRST=0, I=4'b1011 -> O = 1,0,1,1 on cycles 1-4 after the handshake, O_last only on cycle 4, then O_valid=0 and I_ready=1.
- LSB_FIRST=1, I=4'b1011 -> O = 1,1,0,1; O_last on the 4th bit.
- Back-to-back: I_valid held with 4'hA then 4'h5 -> 8 contiguous O_valid cycles carrying 1010 0101; O_last on bits 4 and 8; I_ready high only on the initial idle cycle and on bit 4 and bit 8 cycles.
- Mid-frame I_valid: new word offered on the 2nd bit cycle -> not accepted until the O_last cycle; current frame uncorrupted; new word follows with no gap.
- PISO_PARITY_EN defined, I=4'b1011 -> O = 1,0,1,1,1 with O_last on the 5th bit; I=4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM state encoding,
// bit-order encoding and the frame counter width helper.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit DIR_MSB_FIRST = 1'b0;
    localparam bit DIR_LSB_FIRST = 1'b1;

    // Counter must hold FRAME_LEN-1 down to 0; sizing for frame_len+1 keeps WIDTH=1 legal.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable zero-filling shift register; presents the bit at the output end
// selected by LSB_FIRST.
module piso_shift_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = DIR_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             out_bit
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // Load wins over shift so a new word can enter on the last bit of a frame.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = data;
        end else if (shift) begin
            sreg_d = (LSB_FIRST == DIR_LSB_FIRST) ? (sreg_q >> 1) : (sreg_q << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign out_bit = (LSB_FIRST == DIR_LSB_FIRST) ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready input and framed serial output.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = DIR_MSB_FIRST
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic             O,
    output logic             O_valid,
    output logic             O_last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LOAD_CNT = CW'(FRAME_LEN - 1);

    // Handshake: a word transfers on a posedge where I_valid && I_ready.
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;
    logic          frame_end;
    logic          sreg_bit;
`ifdef PISO_PARITY_EN
    logic          parity_q;
    logic          parity_d;
`endif

    assign frame_end = (state_q == SHIFT) && (cnt_q == '0);
    assign I_ready   = ASYNCRESETN && ((state_q == IDLE) || frame_end);
    assign accept    = I_valid && I_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d  = SHIFT;
            cnt_d    = LOAD_CNT;
`ifdef PISO_PARITY_EN
            parity_d = ^I;
`endif
        end else if (state_q == SHIFT) begin
            if (frame_end) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk     (CLK),
        .rst_n   (ASYNCRESETN),
        .load    (accept),
        .shift   (state_q == SHIFT),
        .data    (I),
        .out_bit (sreg_bit)
    );

    assign O_valid = (state_q == SHIFT);
    assign O_last  = frame_end;
`ifdef PISO_PARITY_EN
    // The data bits are exhausted by count 0; that slot carries the parity bit.
    assign O = (state_q == SHIFT) && (frame_end ? parity_q : sreg_bit);
`else
    assign O = (state_q == SHIFT) && sreg_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first WIDTH=4
// instances share one input stream; a WIDTH=1 instance has its own stream.
module tb_piso_serializer;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [0:0] i_w1 = '0;
    logic       v_w1 = 1'b0;

    logic r0, o0, v0, l0;
    logic r1, o1, v1, l1;
    logic r2, o2, v2, l2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: queues of the serial bits still owed by each instance.
    bit q0[$];
    bit q1[$];
    bit q2[$];

    always #5 CLK = ~CLK;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .I(in_data), .I_valid(in_valid),
        .I_ready(r0), .O(o0), .O_valid(v0), .O_last(l0));

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .I(in_data), .I_valid(in_valid),
        .I_ready(r1), .O(o1), .O_valid(v1), .O_last(l1));

    piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b0)) dut2 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .I(i_w1), .I_valid(v_w1),
        .I_ready(r2), .O(o2), .O_valid(v2), .O_last(l2));

    // Expected {O_valid, O, O_last, I_ready} from a queue of pending bits.
    function automatic logic [3:0] exp_of(input int size, input bit head);
        return {size > 0, (size > 0) ? head : 1'b0, size == 1, rst_n && (size <= 1)};
    endfunction

    function automatic logic [3:0] exp0();
        return exp_of(q0.size(), (q0.size() > 0) ? q0[0] : 1'b0);
    endfunction

    function automatic logic [3:0] exp1();
        return exp_of(q1.size(), (q1.size() > 0) ? q1[0] : 1'b0);
    endfunction

    function automatic logic [3:0] exp2();
        return exp_of(q2.size(), (q2.size() > 0) ? q2[0] : 1'b0);
    endfunction

    task automatic push_word(input logic [3:0] w);
        for (int k = 0; k < 4; k++) begin
            q0.push_back(w[3-k]);
            q1.push_back(w[k]);
        end
`ifdef PISO_PARITY_EN
        q0.push_back(^w);
        q1.push_back(^w);
`endif
    endtask

    // Advance one clock: retire the bit on the line, enqueue any accepted word.
    task automatic tick(output bit acc, output bit acc2);
        logic [3:0] w;
        logic       b;
        acc  = rst_n && (q0.size() <= 1) && in_valid;
        acc2 = rst_n && (q2.size() <= 1) && v_w1;
        w = in_data;
        b = i_w1[0];
        @(posedge CLK);
        if (q0.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (q2.size() > 0) void'(q2.pop_front());
        if (acc) push_word(w);
        if (acc2) begin
            q2.push_back(b);
`ifdef PISO_PARITY_EN
            q2.push_back(b);
`endif
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        bit acc, acc2;
        @(negedge CLK);
        #1;
        n_cmp++;
        if ({v0, o0, l0, r0} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_hold dut0 got %b want 0000", {v0, o0, l0, r0});
        end
        n_cmp++;
        if ({v2, o2, l2, r2} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_hold dut2 got %b want 0000", {v2, o2, l2, r2});
        end
        @(negedge CLK);
        rst_n = 1'b1;
        in_data = 4'b0110;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0()) begin
                n_bad++;
                $display("FAIL reset_pre c=%0d got %b want %b", c, {v0, o0, l0, r0}, exp0());
            end
            tick(acc, acc2);
            if (acc) in_valid = 1'b0;
        end
        // Now on the 2nd bit of the frame: drop reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({v0, o0, l0, r0} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_midframe dut0 got %b want 0000", {v0, o0, l0, r0});
        end
        n_cmp++;
        if ({v1, o1, l1, r1} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_midframe dut1 got %b want 0000", {v1, o1, l1, r1});
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge CLK);
        rst_n = 1'b1;
        in_data = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0() || {v1, o1, l1, r1} !== exp1()) begin
                n_bad++;
                $display("FAIL reset_after c=%0d got %b/%b want %b/%b", c,
                         {v0, o0, l0, r0}, {v1, o1, l1, r1}, exp0(), exp1());
            end
            tick(acc, acc2);
            if (acc) in_valid = 1'b0;
        end
    endtask

    task automatic test_single();
        bit acc, acc2;
        logic [7:0] s0, s1, want0, want1;
        s0 = '0;
        s1 = '0;
`ifdef PISO_PARITY_EN
        want0 = 8'b10111;
        want1 = 8'b11011;
`else
        want0 = 8'b1011;
        want1 = 8'b1101;
`endif
        in_data = 4'b1011;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0() || {v1, o1, l1, r1} !== exp1()) begin
                n_bad++;
                $display("FAIL single c=%0d got %b/%b want %b/%b", c,
                         {v0, o0, l0, r0}, {v1, o1, l1, r1}, exp0(), exp1());
            end
            if (v0) s0 = {s0[6:0], o0};
            if (v1) s1 = {s1[6:0], o1};
            tick(acc, acc2);
            if (acc) in_valid = 1'b0;
        end
        n_cmp++;
        if (s0 !== want0) begin
            n_bad++;
            $display("FAIL single_msb_seq got %b want %b", s0, want0);
        end
        n_cmp++;
        if (s1 !== want1) begin
            n_bad++;
            $display("FAIL single_lsb_seq got %b want %b", s1, want1);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, acc2;
        int n_acc, n_valid, n_last;
        n_acc = 0;
        n_valid = 0;
        n_last = 0;
        in_data = 4'hA;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0()) begin
                n_bad++;
                $display("FAIL b2b c=%0d got %b want %b", c, {v0, o0, l0, r0}, exp0());
            end
            n_valid += int'(v0);
            n_last += int'(l0);
            tick(acc, acc2);
            if (acc) begin
                n_acc++;
                if (n_acc == 1) in_data = 4'h5;
                else in_valid = 1'b0;
            end
        end
`ifdef PISO_PARITY_EN
        n_cmp++;
        if (n_valid != 10) begin
            n_bad++;
            $display("FAIL b2b_valid_cycles got %0d want 10", n_valid);
        end
`else
        n_cmp++;
        if (n_valid != 8) begin
            n_bad++;
            $display("FAIL b2b_valid_cycles got %0d want 8", n_valid);
        end
`endif
        n_cmp++;
        if (n_last != 2) begin
            n_bad++;
            $display("FAIL b2b_last_count got %0d want 2", n_last);
        end
    endtask

    task automatic test_mid_frame();
        bit acc, acc2;
        int n_acc, since;
        n_acc = 0;
        since = 0;
        in_data = 4'h3;
        in_valid = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (n_acc == 1 && since == 1) begin
                in_data = 4'hE;
                in_valid = 1'b1;
            end
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0() || {v1, o1, l1, r1} !== exp1()) begin
                n_bad++;
                $display("FAIL midframe c=%0d got %b/%b want %b/%b", c,
                         {v0, o0, l0, r0}, {v1, o1, l1, r1}, exp0(), exp1());
            end
            tick(acc, acc2);
            since++;
            if (acc) begin
                n_acc++;
                since = 0;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_w1_continuous();
        bit acc, acc2;
        v_w1 = 1'b1;
        i_w1 = 1'($urandom_range(0, 1));
        for (int c = 0; c < 12; c++) begin
            #1;
            n_cmp++;
            if ({v2, o2, l2, r2} !== exp2()) begin
                n_bad++;
                $display("FAIL w1_cont c=%0d got %b want %b", c, {v2, o2, l2, r2}, exp2());
            end
            tick(acc, acc2);
            if (acc2) i_w1 = 1'($urandom_range(0, 1));
        end
        v_w1 = 1'b0;
    endtask

    task automatic test_random();
        bit acc, acc2;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_data = 4'($urandom_range(0, 15));
                in_valid = 1'b1;
            end
            if (!v_w1 && $urandom_range(0, 2) != 0) begin
                i_w1 = 1'($urandom_range(0, 1));
                v_w1 = 1'b1;
            end
            #1;
            n_cmp++;
            if ({v0, o0, l0, r0} !== exp0() || {v1, o1, l1, r1} !== exp1()
                || {v2, o2, l2, r2} !== exp2()) begin
                n_bad++;
                $display("FAIL random c=%0d got %b/%b/%b want %b/%b/%b", c,
                         {v0, o0, l0, r0}, {v1, o1, l1, r1}, {v2, o2, l2, r2},
                         exp0(), exp1(), exp2());
            end
            tick(acc, acc2);
            if (acc) in_valid = 1'b0;
            if (acc2) v_w1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_frame();
        test_w1_continuous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
